// File: rtl/rect_raster.sv
// Rectangle / full-screen fill rasterizer: turns one draw command into a stream of
// single-pixel frame-buffer writes, scanning row-major with clipping at the screen edge.
module rect_raster #(
  parameter int PX_WIDTH  = 160,
  parameter int PX_HEIGHT = 120,
  parameter int COORD_W   = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_clear,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [2:0]         cmd_color,
  output logic [15:0]        wmemaddr,
  output logic [2:0]         wmemdata,
  output logic               wmemwe,
  output logic               busy,
  output logic               done
);

  // Internal coordinate width: wide enough for x+w without wrap and for the screen bounds.
  localparam int CW_MIN = COORD_W + 1;
  localparam int CW_X   = $clog2(PX_WIDTH + 1);
  localparam int CW_Y   = $clog2(PX_HEIGHT + 1);
  localparam int CW_XY  = (CW_X > CW_Y) ? CW_X : CW_Y;
  localparam int CW     = (CW_MIN > CW_XY) ? CW_MIN : CW_XY;

  localparam logic [CW-1:0] X_MAX    = CW'(PX_WIDTH);
  localparam logic [CW-1:0] Y_MAX    = CW'(PX_HEIGHT);
  localparam logic [15:0]   ROW_STEP = 16'(PX_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] x0_q, x_end_q, y_end_q;
  logic [CW-1:0] x_q, y_q;
  logic [15:0]   row_q;
  logic [2:0]    color_q;
  logic          fin_q;
  logic          done_q;

  // Command decode, only consumed on the accepting edge.
  logic [CW-1:0] dx, dy, sum_x, sum_y;
  logic [CW-1:0] n_x0, n_y0, n_xe, n_ye;
  logic [15:0]   n_row;
  logic          n_empty;

  always_comb begin
    dx    = CW'(cmd_x);
    dy    = CW'(cmd_y);
    sum_x = dx + CW'(cmd_w);
    sum_y = dy + CW'(cmd_h);
    if (cmd_clear) begin
      n_x0    = '0;
      n_y0    = '0;
      n_xe    = X_MAX;
      n_ye    = Y_MAX;
      n_empty = 1'b0;
    end else begin
      n_x0    = dx;
      n_y0    = dy;
      n_xe    = (sum_x > X_MAX) ? X_MAX : sum_x;
      n_ye    = (sum_y > Y_MAX) ? Y_MAX : sum_y;
      n_empty = (cmd_w == '0) || (cmd_h == '0) || (dx >= X_MAX) || (dy >= Y_MAX);
    end
    // One multiply per command seeds the row base; pixels then only add.
    n_row = 16'(n_y0) * ROW_STEP;
  end

  logic x_last, y_last;
  assign x_last = (x_q == x_end_q - CW'(1));
  assign y_last = (y_q == y_end_q - CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = n_empty ? DONE : DRAW;
      DRAW:    if (fin_q) state_d = DONE;
      DONE:    if (done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // fin_q marks the cycle where the last write is on the outputs; DRAW drains through it.
  // In DONE, done_q toggles so empty commands spend one silent cycle before the pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      row_q    <= '0;
      color_q  <= '0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
      wmemaddr <= '0;
      wmemdata <= '0;
      wmemwe   <= 1'b0;
    end else begin
      state_q <= state_d;
      wmemwe  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            x0_q    <= n_x0;
            x_end_q <= n_xe;
            y_end_q <= n_ye;
            x_q     <= n_x0;
            y_q     <= n_y0;
            row_q   <= n_row;
            color_q <= cmd_color;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        DRAW: begin
          if (!fin_q) begin
            wmemwe   <= 1'b1;
            wmemaddr <= row_q + 16'(x_q);
            wmemdata <= color_q;
            if (x_last) begin
              x_q   <= x0_q;
              y_q   <= y_q + CW'(1);
              row_q <= row_q + ROW_STEP;
              fin_q <= y_last;
            end else begin
              x_q <= x_q + CW'(1);
            end
          end else begin
            done_q <= 1'b1;
          end
        end
        DONE: done_q <= ~done_q;
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_rect_raster.sv
// Directed bench for rect_raster: expected pixel writes are queued when a command is issued
// and popped as the DUT writes; completion timing is checked against the accept edge.
module tb_rect_raster;

  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [2:0]  cmd_color;
  logic [15:0] wmemaddr;
  logic [2:0]  wmemdata;
  logic        wmemwe;
  logic        busy;
  logic        done;

  rect_raster #(.PX_WIDTH(W), .PX_HEIGHT(H), .COORD_W(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wmemaddr  (wmemaddr),
    .wmemdata  (wmemdata),
    .wmemwe    (wmemwe),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // cyc == k when sampled at the falling edge following rising edge k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [18:0] exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h, input int c);
    int xe, ye;
    if (w == 0 || h == 0 || x >= W || y >= H) return;
    xe = (x + w > W) ? W : x + w;
    ye = (y + h > H) ? H : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        exp_q.push_back({16'(yy * W + xx), 3'(c)});
  endtask

  // Called at a falling edge; leaves cmd_valid high and returns the accept edge number.
  task automatic issue(input logic clear, input int x, input int y, input int w, input int h,
                       input int c, output int n);
    cmd_clear = clear;
    cmd_x     = 8'(x);
    cmd_y     = 8'(y);
    cmd_w     = 8'(w);
    cmd_h     = 8'(h);
    cmd_color = 3'(c);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    chk("ready_before_accept", int'(cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    n = cyc;
  endtask

  task automatic check_write(input string tag);
    logic [18:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    n_checks++;
    assert ({wmemaddr, wmemdata} === e) else begin
      n_fail++;
      $error("FAIL %s_write: observed addr=%0d data=%0d, expected addr=%0d data=%0d",
             tag, wmemaddr, wmemdata, e[18:3], e[2:0]);
    end
  endtask

  // Follows one command from its accept cycle n until done, checking writes and timing.
  task automatic run(input string tag, input int n, output int done_cyc);
    int first, last, nwr, ne;
    bit busy_ok;
    first = -1; last = -1; nwr = 0; busy_ok = 1'b1; done_cyc = -1;
    ne = exp_q.size();
    for (int i = 0; i < ne + 10 && done_cyc < 0; i++) begin
      if (wmemwe) begin
        if (nwr == 0) first = cyc;
        last = cyc;
        nwr++;
        check_write(tag);
      end
      if (!busy) busy_ok = 1'b0;
      if (done) done_cyc = cyc;
      else @(negedge clk);
    end
    chk({tag, "_done_cycle"}, done_cyc, n + ne + 1);
    chk({tag, "_write_count"}, nwr, ne);
    chk({tag, "_first_write_cycle"}, first, (ne > 0) ? n + 1 : -1);
    chk({tag, "_last_write_cycle"}, last, (ne > 0) ? n + ne : -1);
    chk({tag, "_busy_held"}, int'(busy_ok), 1);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
    if (done_cyc >= 0) begin
      chk({tag, "_we_at_done"}, int'(wmemwe), 0);
      chk({tag, "_ready_at_done"}, int'(cmd_ready), 0);
      @(negedge clk);
      chk({tag, "_ready_after_done"}, int'(cmd_ready), 1);
      chk({tag, "_done_single_pulse"}, int'(done), 0);
    end
  endtask

  initial begin
    int n, n2, dc, nwr;
    clr = 1'b1;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    #1;
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_we", int'(wmemwe), 0);
    chk("reset_addr", int'(wmemaddr), 0);
    chk("reset_data", int'(wmemdata), 0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Plain rectangle: 482..484, 642..644.
    push_rect(2, 3, 3, 2, 5);
    issue(1'b0, 2, 3, 3, 2, 5, n);
    cmd_valid = 1'b0;
    run("rect", n, dc);

    // Clipped at the bottom-right corner: 19198, 19199.
    push_rect(158, 119, 10, 10, 3);
    issue(1'b0, 158, 119, 10, 10, 3, n);
    cmd_valid = 1'b0;
    run("clip", n, dc);

    // Empty commands.
    issue(1'b0, 7, 7, 0, 4, 1, n);
    cmd_valid = 1'b0;
    run("empty_w0", n, dc);
    issue(1'b0, 200, 7, 4, 4, 1, n);
    cmd_valid = 1'b0;
    run("empty_x200", n, dc);

    // Full-screen clear.
    push_rect(0, 0, W, H, 0);
    issue(1'b1, 9, 9, 1, 1, 0, n);
    cmd_valid = 1'b0;
    run("clear", n, dc);

    // Valid held high; fields switch to a second command right after the first is taken.
    push_rect(10, 10, 2, 2, 1);
    issue(1'b0, 10, 10, 2, 2, 1, n);
    cmd_x = 8'd20; cmd_y = 8'd100; cmd_w = 8'd3; cmd_h = 8'd1; cmd_color = 3'd4;
    run("b2b_first", n, dc);
    push_rect(20, 100, 3, 1, 4);
    issue(1'b0, 20, 100, 3, 1, 4, n2);
    cmd_valid = 1'b0;
    chk("b2b_second_accept_cycle", n2, dc + 2);
    run("b2b_second", n2, dc);

    // Reset after four writes of a 10x10 rectangle.
    push_rect(0, 0, 4, 1, 6);
    issue(1'b0, 0, 0, 10, 10, 6, n);
    cmd_valid = 1'b0;
    nwr = 0;
    for (int i = 0; i < 20 && nwr < 4; i++) begin
      if (wmemwe) begin
        nwr++;
        check_write("abort");
      end
      if (nwr < 4) @(negedge clk);
    end
    chk("abort_writes_before_clr", nwr, 4);
    #1 clr = 1'b1;
    #1;
    chk("abort_we_async", int'(wmemwe), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr", int'(wmemaddr), 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_we_held", int'(wmemwe), 0);
    clr = 1'b0;
    @(negedge clk);
    chk("abort_no_writes_after", int'(wmemwe), 0);
    push_rect(5, 5, 1, 1, 2);
    issue(1'b0, 5, 5, 1, 1, 2, n);
    cmd_valid = 1'b0;
    run("after_abort", n, dc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
